// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: runs each instruction over 2..5 clocks plus
// memory wait states, driving the enables and selects of the shared-memory
// multicycle datapath. All outputs are decoded from the current state.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   FETCH    0  | read instruction at PC, PC <= PC+4 when memory ready
//   DECODE   1  | latch opcode, compute branch target into ALUOut
//   MEMADR   2  | effective address rs + signext(imm)
//   MEMREAD  3  | data read at ALUOut, wait for memory
//   MEMWB    4  | write MDR to rt
//   MEMWRITE 5  | data write at ALUOut, wait for memory
//   EXEC_R   6  | R-type ALU operation selected by Funct
//   RTYPE_WB 7  | write ALUOut to rd
//   EXEC_I   8  | immediate ALU operation selected by opcode
//   ITYPE_WB 9  | write ALUOut to rt
//   BRANCH  10  | compare rs/rt, conditionally take target from ALUOut
//   JUMP    11  | PC <= jump target
//   JAL     12  | PC <= jump target, $31 <= PC (already PC+4)
//   JR      13  | PC <= register A
module multicycle_control #(
  parameter logic MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_RTYPE_WB = 4'd7;
  localparam logic [3:0] S_EXEC_I   = 4'd8;
  localparam logic [3:0] S_ITYPE_WB = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_JAL      = 4'd12;
  localparam logic [3:0] S_JR       = 4'd13;

  localparam logic [2:0] ALU_FUNCT = 3'b111;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b000;
  localparam logic [2:0] ALU_AND   = 3'b110;
  localparam logic [2:0] ALU_SUB   = 3'b001;

  logic [3:0] state_q, state_d;
  logic [5:0] op_q;
  logic       rdy;

  // With wait states disabled the memory is assumed to finish every access in one cycle.
  assign rdy   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state = reset ? S_FETCH : state_q;

  // State and latched opcode; opcode is only captured in DECODE so later
  // states ignore whatever the IR bus shows after the IR is reloaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= OP;
    end
  end

  // Next-state and output decode; reset overrides every output so no strobe leaks during reset.
  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 2'b00;
    MemToReg   = 2'b00;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 3'b000;
    PCSource   = 2'b00;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        IRWrite = rdy;
        PCWrite = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALU_ADD;
        case (OP)
          6'h00:                      state_d = (Funct == 6'h08) ? S_JR : S_EXEC_R;
          6'h23, 6'h2b:               state_d = S_MEMADR;
          6'h08, 6'h0c, 6'h0d, 6'h0f: state_d = S_EXEC_I;
          6'h04, 6'h05:               state_d = S_BRANCH;
          6'h02:                      state_d = S_JUMP;
          6'h03:                      state_d = S_JAL;
          default: begin
            state_d    = S_FETCH;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ALU_ADD;
        state_d = (op_q == 6'h23) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemToReg   = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = rdy;
        if (rdy) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
        state_d = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_q)
          6'h0c:   ALUOp = ALU_AND;
          6'h0d:   ALUOp = ALU_OR;
          6'h0f:   ALUOp = ALU_LUI;
          default: ALUOp = ALU_ADD;
        endcase
        state_d = S_ITYPE_WB;
      end
      S_ITYPE_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_SUB;
        PCSource   = 2'b01;
        PCWrite    = ((op_q == 6'h04) & Zero) | ((op_q == 6'h05) & ~Zero);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        RegWrite   = 1'b1;
        RegDst     = 2'b10;
        MemToReg   = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b11;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      PCWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 2'b00;
      MemToReg   = 2'b00;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 3'b000;
      PCSource   = 2'b00;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus side expands each
// instruction into its expected cycle-by-cycle output vectors and queues
// them; the monitor pops one per cycle and compares.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OP = 6'd0, Funct = 6'd0;
  logic       Zero = 1'b0, mem_ready = 1'b0;

  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, instr_done;
  logic [1:0] RegDst, MemToReg, ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state;

  logic       PCWrite2, IorD2, MemRead2, MemWrite2, IRWrite2, RegWrite2, ALUSrcA2, instr_done2;
  logic [1:0] RegDst2, MemToReg2, ALUSrcB2, PCSource2;
  logic [2:0] ALUOp2;
  logic [3:0] state2;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int done_seen = 0, done_exp = 0;
  logic chk2 = 1'b0;
  logic [23:0] sb[$];

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .instr_done(instr_done));

  // Second copy sees mem_ready stuck low; with waits disabled it must still progress.
  multicycle_control #(.MEM_WAIT_EN(1'b0)) dut_nowait (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero), .mem_ready(1'b0),
    .PCWrite(PCWrite2), .IorD(IorD2), .MemRead(MemRead2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
    .RegDst(RegDst2), .MemToReg(MemToReg2), .RegWrite(RegWrite2), .ALUSrcA(ALUSrcA2),
    .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2), .PCSource(PCSource2), .state(state2), .instr_done(instr_done2));

  wire [22:0] vec1 = {state, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
                      RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done};
  wire [22:0] vec2 = {state2, PCWrite2, IorD2, MemRead2, MemWrite2, IRWrite2, RegDst2, MemToReg2,
                      RegWrite2, ALUSrcA2, ALUSrcB2, ALUOp2, PCSource2, instr_done2};

  function automatic logic supported(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h04, 6'h05, 6'h02, 6'h03};
  endfunction

  // Reference outputs for one cycle of an instruction; st = -1 means reset held.
  function automatic logic [22:0] exp_out(input int st, input logic [5:0] op,
                                          input logic z, input logic rdy);
    logic pcw, iord, mr, mw, irw, rw, asa, dn;
    logic [1:0] rd, m2r, asb, pcs;
    logic [2:0] aop;
    {pcw, iord, mr, mw, irw, rw, asa, dn} = '0;
    {rd, m2r, asb, pcs} = '0;
    aop = 3'b000;
    case (st)
      0:  begin mr = 1; asb = 2'b01; aop = 3'b100; irw = rdy; pcw = rdy; end
      1:  begin asb = 2'b11; aop = 3'b100; dn = !supported(op); end
      2:  begin asa = 1; asb = 2'b10; aop = 3'b100; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 2'b01; dn = 1; end
      5:  begin mw = 1; iord = 1; dn = rdy; end
      6:  begin asa = 1; aop = 3'b111; end
      7:  begin rw = 1; rd = 2'b01; dn = 1; end
      8:  begin
            asa = 1; asb = 2'b10;
            aop = (op == 6'h0c) ? 3'b110 : (op == 6'h0d) ? 3'b101 : (op == 6'h0f) ? 3'b000 : 3'b100;
          end
      9:  begin rw = 1; dn = 1; end
      10: begin asa = 1; aop = 3'b001; pcs = 2'b01; dn = 1;
                pcw = (op == 6'h04) ? z : !z; end
      11: begin pcw = 1; pcs = 2'b10; dn = 1; end
      12: begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; dn = 1; end
      13: begin pcw = 1; pcs = 2'b11; dn = 1; end
      default: ;
    endcase
    return {(st < 0) ? 4'd0 : 4'(st), pcw, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, dn};
  endfunction

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      OP = 6'($urandom); Funct = 6'($urandom); Zero = 1'($urandom); mem_ready = 1'($urandom);
      sb.push_back({chk2, exp_out(-1, 6'd0, 1'b0, 1'b0)});
    end
  endtask

  // Expand one instruction into cycles; abort_at >= 0 raises reset on that cycle instead.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw, input int abort_at);
    int   sts[$];
    logic rdys[$];
    repeat (fw) begin sts.push_back(0); rdys.push_back(1'b0); end
    sts.push_back(0); rdys.push_back(1'b1);
    sts.push_back(1); rdys.push_back(1'($urandom));
    if (op == 6'h00 && fn == 6'h08) begin sts.push_back(13); rdys.push_back(1'($urandom)); end
    else if (op == 6'h00) begin
      sts.push_back(6); rdys.push_back(1'($urandom));
      sts.push_back(7); rdys.push_back(1'($urandom));
    end else if (op == 6'h23 || op == 6'h2b) begin
      int ms = (op == 6'h23) ? 3 : 5;
      sts.push_back(2); rdys.push_back(1'($urandom));
      repeat (mw) begin sts.push_back(ms); rdys.push_back(1'b0); end
      sts.push_back(ms); rdys.push_back(1'b1);
      if (op == 6'h23) begin sts.push_back(4); rdys.push_back(1'($urandom)); end
    end else if (op inside {6'h08, 6'h0c, 6'h0d, 6'h0f}) begin
      sts.push_back(8); rdys.push_back(1'($urandom));
      sts.push_back(9); rdys.push_back(1'($urandom));
    end else if (op == 6'h04 || op == 6'h05) begin sts.push_back(10); rdys.push_back(1'($urandom)); end
    else if (op == 6'h02) begin sts.push_back(11); rdys.push_back(1'($urandom)); end
    else if (op == 6'h03) begin sts.push_back(12); rdys.push_back(1'($urandom)); end
    for (int i = 0; i < sts.size(); i++) begin
      @(posedge clk); #1;
      reset     = 1'b0;
      OP        = (sts[i] == 1) ? op : 6'($urandom);
      Funct     = (sts[i] == 1) ? fn : 6'($urandom);
      Zero      = (sts[i] == 10) ? z : 1'($urandom);
      mem_ready = rdys[i];
      if (i == abort_at) begin
        reset = 1'b1;
        sb.push_back({chk2, exp_out(-1, 6'd0, 1'b0, 1'b0)});
        return;
      end
      sb.push_back({chk2, exp_out(sts[i], op, z, rdys[i])});
    end
    done_exp++;
  endtask

  // Monitor: one expected vector per cycle, sampled mid-cycle.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (instr_done === 1'b1) done_seen++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (vec1 !== e[22:0]) begin
          n_fail++;
          $display("FAIL dut_outputs cyc%0d got %h exp %h", cyc, vec1, e[22:0]);
        end
        if (e[23]) begin
          n_tests++;
          if (vec2 !== e[22:0]) begin
            n_fail++;
            $display("FAIL nowait_outputs cyc%0d got %h exp %h", cyc, vec2, e[22:0]);
          end
        end
      end
    end
  end

  initial begin
    logic [5:0] iops[4];
    iops[0] = 6'h08; iops[1] = 6'h0c; iops[2] = 6'h0d; iops[3] = 6'h0f;
    apply_reset(2);
    // directed: addi, lw with waits, branches, jumps, unsupported, reset abort of sw
    run_instr(6'h08, 6'h00, 1'b0, 0, 0, -1);
    run_instr(6'h23, 6'h00, 1'b0, 2, 3, -1);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, -1);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, -1);
    run_instr(6'h05, 6'h00, 1'b1, 0, 0, -1);
    run_instr(6'h05, 6'h00, 1'b0, 1, 0, -1);
    run_instr(6'h03, 6'h00, 1'b0, 0, 0, -1);
    run_instr(6'h00, 6'h08, 1'b0, 0, 0, -1);
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, -1);
    run_instr(6'h3f, 6'h00, 1'b0, 0, 0, -1);
    run_instr(6'h2b, 6'h00, 1'b0, 0, 3, 4);
    run_instr(6'h2b, 6'h00, 1'b0, 1, 2, -1);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, -1);
    // no-wait copy: both instances follow the same path while ready stays high where it matters
    apply_reset(1);
    chk2 = 1'b1;
    run_instr(6'h2b, 6'h00, 1'b0, 0, 0, -1);
    run_instr(6'h23, 6'h00, 1'b0, 0, 0, -1);
    run_instr(6'h0d, 6'h00, 1'b0, 0, 0, -1);
    apply_reset(1);
    chk2 = 1'b0;
    // randomized mix
    for (int k = 0; k < 300; k++) begin
      logic [5:0] op, fn;
      int sel;
      sel = $urandom_range(0, 9);
      fn  = 6'($urandom);
      case (sel)
        0: begin op = 6'h00; if (fn == 6'h08) fn = 6'h21; end
        1: begin op = 6'h00; fn = 6'h08; end
        2: op = 6'h23;
        3: op = 6'h2b;
        4: op = iops[$urandom_range(0, 3)];
        5: op = ($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05;
        6: op = 6'h02;
        7: op = 6'h03;
        default: op = 6'($urandom);
      endcase
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1);
      if ($urandom_range(0, 19) == 0) apply_reset($urandom_range(1, 2));
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    @(negedge clk);
    n_tests++;
    if (done_seen != done_exp) begin
      n_fail++;
      $display("FAIL instr_done_count got %0d exp %0d", done_seen, done_exp);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
